// File: rtl/fetch_redirect_unit_if.sv
// Front-end bus between the fetch redirect unit, the program-counter
// register, instruction memory and the IF/ID consumers.
interface fetch_redirect_unit_if;
    logic [31:0] PCResult;
    logic [31:0] Instruction;
    logic        Stall;
    logic        Flush;
    logic        Redirect;
    logic [31:0] RedirectTarget;
    logic [31:0] PCNext;
    logic [31:0] IF_ID_Instruction;
    logic [31:0] IF_ID_PCPlus4;
    logic        IF_ID_Valid;
    logic        RedirectPending;

    modport master (
        output PCResult, Instruction, Stall, Flush, Redirect, RedirectTarget,
        input  PCNext, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid, RedirectPending
    );

    modport slave (
        input  PCResult, Instruction, Stall, Flush, Redirect, RedirectTarget,
        output PCNext, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid, RedirectPending
    );
endinterface

// File: rtl/fetch_redirect_unit.sv
// Next-PC selection (boot, sequential, stall, redirect with deferral while
// stalled) and the IF/ID pipeline register.
module fetch_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    fetch_redirect_unit_if.slave  bus
);

    localparam logic [31:0] STEP = PC_STEP[31:0];

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        pending_q, pending_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pcplus4_q, ifid_pcplus4_d;
    logic        ifid_valid_q, ifid_valid_d;

    logic [31:0] pc_seq;
    logic [31:0] pc_next;
    logic        bubble;

    assign pc_seq = bus.PCResult + STEP;

    // Next PC is purely a function of PC, control inputs and state;
    // Instruction deliberately has no path here.
    always_comb begin
        pc_next = RESET_PC;
        unique case (state_q)
            BOOT: pc_next = RESET_PC;
            RUN: begin
                if (bus.Redirect && !bus.Stall)
                    pc_next = bus.RedirectTarget;
                else if (bus.Stall)
                    pc_next = bus.PCResult;
                else
                    pc_next = pc_seq;
            end
            PEND: begin
                if (bus.Stall)
                    pc_next = bus.PCResult;
                else if (bus.Redirect)
                    pc_next = bus.RedirectTarget;
                else
                    pc_next = pend_target_q;
            end
            default: pc_next = RESET_PC;
        endcase
    end

    // Anything fetched under a redirect, flush or the release of a deferred
    // redirect is wrong-path, so the bubble outranks a stall hold.
    assign bubble = bus.Redirect || bus.Flush || ((state_q == PEND) && !bus.Stall);

    always_comb begin
        state_d        = state_q;
        pend_target_d  = pend_target_q;
        ifid_instr_d   = ifid_instr_q;
        ifid_pcplus4_d = ifid_pcplus4_q;
        ifid_valid_d   = ifid_valid_q;

        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (bus.Redirect && bus.Stall) begin
                    state_d       = PEND;
                    pend_target_d = bus.RedirectTarget;
                end
            end
            PEND: begin
                if (bus.Redirect)
                    pend_target_d = bus.RedirectTarget;
                if (!bus.Stall)
                    state_d = RUN;
            end
            default: state_d = BOOT;
        endcase

        if (state_q == BOOT) begin
            ifid_instr_d   = 32'h0;
            ifid_pcplus4_d = 32'h0;
            ifid_valid_d   = 1'b0;
        end else if (bubble) begin
            ifid_instr_d   = 32'h0;
            ifid_pcplus4_d = 32'h0;
            ifid_valid_d   = 1'b0;
        end else if (!bus.Stall) begin
            ifid_instr_d   = bus.Instruction;
            ifid_pcplus4_d = pc_seq;
            ifid_valid_d   = 1'b1;
        end
    end

    assign pending_d = (state_d == PEND);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q        <= BOOT;
            pend_target_q  <= 32'h0;
            pending_q      <= 1'b0;
            ifid_instr_q   <= 32'h0;
            ifid_pcplus4_q <= 32'h0;
            ifid_valid_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            pend_target_q  <= pend_target_d;
            pending_q      <= pending_d;
            ifid_instr_q   <= ifid_instr_d;
            ifid_pcplus4_q <= ifid_pcplus4_d;
            ifid_valid_q   <= ifid_valid_d;
        end
    end

    assign bus.PCNext            = pc_next;
    assign bus.IF_ID_Instruction = ifid_instr_q;
    assign bus.IF_ID_PCPlus4     = ifid_pcplus4_q;
    assign bus.IF_ID_Valid       = ifid_valid_q;
    assign bus.RedirectPending   = pending_q;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit with a modelled PC register and a
// synthetic instruction memory ({pc[15:0], 16'h0013}).
module tb_fetch_redirect_unit;

    logic clk;
    logic rst_n;
    logic [31:0] pc_reg;
    int n_cmp;
    int n_err;

    fetch_redirect_unit_if bus();

    fetch_redirect_unit #(
        .RESET_PC(32'h0000_0000),
        .PC_STEP (4)
    ) dut (
        .Clk  (clk),
        .Rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program-counter register: no reset, loads PCNext every edge.
    always @(posedge clk) pc_reg <= bus.PCNext;
    assign bus.PCResult    = pc_reg;
    assign bus.Instruction = {pc_reg[15:0], 16'h0013};

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[15:0], 16'h0013};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_cmp++; if (bus.PCNext !== 32'h0) begin n_err++; $display("FAIL reset_pcnext: got %h want %h", bus.PCNext, 32'h0); end
        n_cmp++; if (bus.IF_ID_Valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.IF_ID_Valid); end
        n_cmp++; if (bus.IF_ID_Instruction !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h want 0", bus.IF_ID_Instruction); end
        n_cmp++; if (bus.IF_ID_PCPlus4 !== 32'h0) begin n_err++; $display("FAIL reset_pp4: got %h want 0", bus.IF_ID_PCPlus4); end
        n_cmp++; if (bus.RedirectPending !== 1'b0) begin n_err++; $display("FAIL reset_pending: got %b want 0", bus.RedirectPending); end
        $display("test_reset done");
    endtask

    task automatic test_boot();
        rst_n = 1'b1;
        #1;
        n_cmp++; if (bus.PCResult !== 32'h0) begin n_err++; $display("FAIL boot_pc0: got %h want 0", bus.PCResult); end
        n_cmp++; if (bus.PCNext !== 32'h0) begin n_err++; $display("FAIL boot_pcnext: got %h want 0", bus.PCNext); end
        step();
        n_cmp++; if (bus.PCResult !== 32'h0) begin n_err++; $display("FAIL boot_pc1: got %h want 0", bus.PCResult); end
        n_cmp++; if (bus.IF_ID_Valid !== 1'b0) begin n_err++; $display("FAIL boot_valid_early: got %b want 0", bus.IF_ID_Valid); end
        step();
        n_cmp++; if (bus.PCResult !== 32'h4) begin n_err++; $display("FAIL boot_pc2: got %h want 4", bus.PCResult); end
        n_cmp++; if (bus.IF_ID_Valid !== 1'b1) begin n_err++; $display("FAIL boot_valid: got %b want 1", bus.IF_ID_Valid); end
        n_cmp++; if (bus.IF_ID_PCPlus4 !== 32'h4) begin n_err++; $display("FAIL boot_pp4: got %h want 4", bus.IF_ID_PCPlus4); end
        n_cmp++; if (bus.IF_ID_Instruction !== inst_of(32'h0)) begin n_err++; $display("FAIL boot_instr: got %h want %h", bus.IF_ID_Instruction, inst_of(32'h0)); end
        step();
        n_cmp++; if (bus.PCResult !== 32'h8) begin n_err++; $display("FAIL boot_pc3: got %h want 8", bus.PCResult); end
        n_cmp++; if (bus.IF_ID_PCPlus4 !== 32'h8) begin n_err++; $display("FAIL boot_pp4b: got %h want 8", bus.IF_ID_PCPlus4); end
        $display("test_boot done");
    endtask

    task automatic test_stall();
        step(); step();
        n_cmp++; if (bus.PCResult !== 32'h10) begin n_err++; $display("FAIL stall_setup_pc: got %h want 10", bus.PCResult); end
        bus.Stall = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (bus.PCNext !== 32'h10) begin n_err++; $display("FAIL stall_pcnext[%0d]: got %h want 10", i, bus.PCNext); end
            step();
            n_cmp++; if (bus.IF_ID_Instruction !== inst_of(32'hC) || bus.IF_ID_PCPlus4 !== 32'h10 || bus.IF_ID_Valid !== 1'b1) begin
                n_err++; $display("FAIL stall_hold[%0d]: got %h/%h/%b want %h/10/1", i, bus.IF_ID_Instruction, bus.IF_ID_PCPlus4, bus.IF_ID_Valid, inst_of(32'hC));
            end
        end
        bus.Stall = 1'b0;
        #1;
        n_cmp++; if (bus.PCNext !== 32'h14) begin n_err++; $display("FAIL stall_resume_pcnext: got %h want 14", bus.PCNext); end
        step();
        n_cmp++; if (bus.PCResult !== 32'h14) begin n_err++; $display("FAIL stall_resume_pc: got %h want 14", bus.PCResult); end
        n_cmp++; if (bus.IF_ID_Instruction !== inst_of(32'h10) || bus.IF_ID_PCPlus4 !== 32'h14) begin
            n_err++; $display("FAIL stall_resume_ifid: got %h/%h want %h/14", bus.IF_ID_Instruction, bus.IF_ID_PCPlus4, inst_of(32'h10));
        end
        $display("test_stall done");
    endtask

    task automatic test_redirect();
        step(); step(); step();
        n_cmp++; if (bus.PCResult !== 32'h20) begin n_err++; $display("FAIL redir_setup_pc: got %h want 20", bus.PCResult); end
        bus.Redirect = 1'b1;
        bus.RedirectTarget = 32'h100;
        #1;
        n_cmp++; if (bus.PCNext !== 32'h100) begin n_err++; $display("FAIL redir_pcnext: got %h want 100", bus.PCNext); end
        step();
        bus.Redirect = 1'b0;
        n_cmp++; if (bus.PCResult !== 32'h100) begin n_err++; $display("FAIL redir_pc: got %h want 100", bus.PCResult); end
        n_cmp++; if (bus.IF_ID_Valid !== 1'b0 || bus.IF_ID_Instruction !== 32'h0) begin n_err++; $display("FAIL redir_bubble: got %b/%h want 0/0", bus.IF_ID_Valid, bus.IF_ID_Instruction); end
        step();
        n_cmp++; if (bus.IF_ID_Valid !== 1'b1 || bus.IF_ID_PCPlus4 !== 32'h104) begin n_err++; $display("FAIL redir_target_ifid: got %b/%h want 1/104", bus.IF_ID_Valid, bus.IF_ID_PCPlus4); end
        n_cmp++; if (bus.IF_ID_Instruction !== inst_of(32'h100)) begin n_err++; $display("FAIL redir_target_instr: got %h want %h", bus.IF_ID_Instruction, inst_of(32'h100)); end
        $display("test_redirect done");
    endtask

    task automatic test_deferred();
        bus.Stall = 1'b1;
        bus.Redirect = 1'b1;
        bus.RedirectTarget = 32'h200;
        #1;
        n_cmp++; if (bus.PCNext !== 32'h104) begin n_err++; $display("FAIL defer_pcnext0: got %h want 104", bus.PCNext); end
        step();
        n_cmp++; if (bus.RedirectPending !== 1'b1) begin n_err++; $display("FAIL defer_pending0: got %b want 1", bus.RedirectPending); end
        n_cmp++; if (bus.IF_ID_Valid !== 1'b0) begin n_err++; $display("FAIL defer_bubble: got %b want 0", bus.IF_ID_Valid); end
        bus.RedirectTarget = 32'h300;
        #1;
        n_cmp++; if (bus.PCNext !== 32'h104) begin n_err++; $display("FAIL defer_pcnext1: got %h want 104", bus.PCNext); end
        step();
        bus.Redirect = 1'b0;
        step();
        n_cmp++; if (bus.PCResult !== 32'h104 || bus.RedirectPending !== 1'b1) begin n_err++; $display("FAIL defer_hold: got %h/%b want 104/1", bus.PCResult, bus.RedirectPending); end
        bus.Stall = 1'b0;
        #1;
        n_cmp++; if (bus.PCNext !== 32'h300) begin n_err++; $display("FAIL defer_release_pcnext: got %h want 300", bus.PCNext); end
        step();
        n_cmp++; if (bus.PCResult !== 32'h300 || bus.RedirectPending !== 1'b0) begin n_err++; $display("FAIL defer_release: got %h/%b want 300/0", bus.PCResult, bus.RedirectPending); end
        n_cmp++; if (bus.IF_ID_Valid !== 1'b0) begin n_err++; $display("FAIL defer_release_bubble: got %b want 0", bus.IF_ID_Valid); end
        step();
        n_cmp++; if (bus.IF_ID_Valid !== 1'b1 || bus.IF_ID_PCPlus4 !== 32'h304) begin n_err++; $display("FAIL defer_target_ifid: got %b/%h want 1/304", bus.IF_ID_Valid, bus.IF_ID_PCPlus4); end
        // Redirect arriving on the releasing cycle of PEND overrides the stored target.
        bus.Stall = 1'b1;
        bus.Redirect = 1'b1;
        bus.RedirectTarget = 32'h400;
        step();
        bus.Stall = 1'b0;
        bus.RedirectTarget = 32'h500;
        #1;
        n_cmp++; if (bus.PCNext !== 32'h500) begin n_err++; $display("FAIL defer_override_pcnext: got %h want 500", bus.PCNext); end
        step();
        bus.Redirect = 1'b0;
        n_cmp++; if (bus.PCResult !== 32'h500 || bus.RedirectPending !== 1'b0) begin n_err++; $display("FAIL defer_override: got %h/%b want 500/0", bus.PCResult, bus.RedirectPending); end
        $display("test_deferred done");
    endtask

    task automatic test_flush_wrap();
        step();
        n_cmp++; if (bus.IF_ID_Valid !== 1'b1 || bus.IF_ID_PCPlus4 !== 32'h504) begin n_err++; $display("FAIL flush_setup: got %b/%h want 1/504", bus.IF_ID_Valid, bus.IF_ID_PCPlus4); end
        bus.Flush = 1'b1;
        bus.Stall = 1'b1;
        #1;
        n_cmp++; if (bus.PCNext !== 32'h504) begin n_err++; $display("FAIL flush_pcnext: got %h want 504", bus.PCNext); end
        step();
        bus.Flush = 1'b0;
        bus.Stall = 1'b0;
        n_cmp++; if (bus.IF_ID_Valid !== 1'b0 || bus.IF_ID_Instruction !== 32'h0 || bus.PCResult !== 32'h504) begin
            n_err++; $display("FAIL flush_stall: got %b/%h/%h want 0/0/504", bus.IF_ID_Valid, bus.IF_ID_Instruction, bus.PCResult);
        end
        bus.Redirect = 1'b1;
        bus.RedirectTarget = 32'hFFFF_FFFC;
        step();
        bus.Redirect = 1'b0;
        #1;
        n_cmp++; if (bus.PCNext !== 32'h0) begin n_err++; $display("FAIL wrap_pcnext: got %h want 0", bus.PCNext); end
        step();
        n_cmp++; if (bus.IF_ID_Valid !== 1'b1 || bus.IF_ID_PCPlus4 !== 32'h0) begin n_err++; $display("FAIL wrap_pp4: got %b/%h want 1/0", bus.IF_ID_Valid, bus.IF_ID_PCPlus4); end
        $display("test_flush_wrap done");
    endtask

    task automatic test_midrun_reset();
        bus.Stall = 1'b1;
        bus.Redirect = 1'b1;
        bus.RedirectTarget = 32'h600;
        step();
        bus.Redirect = 1'b0;
        n_cmp++; if (bus.RedirectPending !== 1'b1) begin n_err++; $display("FAIL mrst_setup: got %b want 1", bus.RedirectPending); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.RedirectPending !== 1'b0) begin n_err++; $display("FAIL mrst_pending: got %b want 0", bus.RedirectPending); end
        n_cmp++; if (bus.PCNext !== 32'h0) begin n_err++; $display("FAIL mrst_pcnext: got %h want 0", bus.PCNext); end
        n_cmp++; if (bus.IF_ID_Valid !== 1'b0 || bus.IF_ID_Instruction !== 32'h0 || bus.IF_ID_PCPlus4 !== 32'h0) begin
            n_err++; $display("FAIL mrst_ifid: got %b/%h/%h want 0/0/0", bus.IF_ID_Valid, bus.IF_ID_Instruction, bus.IF_ID_PCPlus4);
        end
        bus.Stall = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step(); step();
        n_cmp++; if (bus.IF_ID_Valid !== 1'b1 || bus.IF_ID_PCPlus4 !== 32'h4) begin n_err++; $display("FAIL mrst_reboot: got %b/%h want 1/4", bus.IF_ID_Valid, bus.IF_ID_PCPlus4); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.IF_ID_Valid !== 1'b0 || bus.IF_ID_PCPlus4 !== 32'h0) begin n_err++; $display("FAIL mrst_async_ifid: got %b/%h want 0/0", bus.IF_ID_Valid, bus.IF_ID_PCPlus4); end
        $display("test_midrun_reset done");
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.Stall = 1'b0;
        bus.Flush = 1'b0;
        bus.Redirect = 1'b0;
        bus.RedirectTarget = 32'h0;
        step(); step();
        test_reset();
        test_boot();
        test_stall();
        test_redirect();
        test_deferred();
        test_flush_wrap();
        test_midrun_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_redirect_unit.md
# fetch_redirect_unit

Front-end control stage that drives `PCNext` into the program-counter register and captures fetched instructions into the IF/ID pipeline register. It sequences PC increment, stall hold, and branch/jump redirect. A redirect that arrives while the front end is stalled is held pending and applied on the first unstalled cycle. Because the program-counter register has no reset, this block also supplies the boot vector.

## Interface
- `RESET_PC`, default 32'h0000_0000: boot address driven on `PCNext` during and just after reset.
- `PC_STEP`, default 4: sequential PC increment in bytes.

Ports:
- `Clk`  in  1  single clock; all state updates on posedge.
- `Rst_n`  in  1  asynchronous, active-low reset.
- `PCResult`  in  32  current PC from the program-counter register.
- `Instruction`  in  32  instruction-memory read data for `PCResult`.
- `Stall`  in  1  hold PC and IF/ID this cycle.
- `Flush`  in  1  squash IF/ID contents; the PC is not affected.
- `Redirect`  in  1  taken branch/jump resolved downstream.
- `RedirectTarget`  in  32  target address, valid when `Redirect`=1.
- `PCNext`  out  32  next PC (combinational).
- `IF_ID_Instruction`  out  32  registered instruction; 0 (NOP) when invalid.
- `IF_ID_PCPlus4`  out  32  registered `PCResult + PC_STEP`.
- `IF_ID_Valid`  out  1  IF/ID holds a live instruction.
- `RedirectPending`  out  1  a deferred redirect is stored.

## Operation
- FSM states: BOOT, RUN, PEND.
- Reset:
  - While `Rst_n`=0: state=BOOT, `PCNext`=`RESET_PC`.
  - All IF/ID outputs are 0, `RedirectPending`=0, pending target=0.
- BOOT:
  - `PCNext`=`RESET_PC`. The IF/ID register loads invalid (valid=0, instruction=0).
  - Next state is RUN unconditionally. `Stall`, `Flush` and `Redirect` are ignored.
- RUN, `PCNext` priority (first match wins):
  - `Redirect`=1 and `Stall`=0: `RedirectTarget`.
  - `Stall`=1: `PCResult`.
  - Otherwise: `PCResult + PC_STEP`.
- RUN with `Redirect`=1 and `Stall`=1: latch `RedirectTarget` into the pending register and go to PEND.
- PEND:
  - `Stall`=1: `PCNext`=`PCResult`, stay in PEND.
  - `Stall`=0: `PCNext`=pending target, go to RUN.
  - `Redirect`=1 in PEND (any `Stall`): the pending target is overwritten with `RedirectTarget`. If `Stall`=0 the new target is used directly.
- `RedirectPending` = (state==PEND).
- IF/ID register update, evaluated at each posedge outside BOOT (first match wins):
  - `Redirect`, `Flush`, or PEND-with-`Stall`=0: load a bubble (valid=0, instruction=0, PCPlus4=0).
  - `Stall`=1: hold all fields.
  - Otherwise: load `Instruction`, `PCResult + PC_STEP`, valid=1.
- Squash priority: a bubble load wins over `Stall`. A wrong-path instruction is never held.
- Arithmetic: 32-bit unsigned add; wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0). No alignment checking.

## Timing
- `PCNext` is combinational from `PCResult`, `Stall`, `Redirect`, `RedirectTarget` and state. No path from `Instruction` to `PCNext`.
- Sequential fetch: the IF/ID output updates 1 cycle after `PCResult` presents the address.
- Redirect in RUN, unstalled: `PCResult` equals the target after the next edge. The first target instruction is valid in IF/ID 2 edges after `Redirect`.
- Deferred redirect: the target reaches `PCResult` on the edge that ends the first `Stall`=0 cycle.
- `Rst_n` assertion mid-operation: immediate return to BOOT. Pending target and IF/ID are cleared asynchronously; `PCNext`=`RESET_PC` combinationally.
- Reset deassertion is synchronised externally. The first edge after release is spent in BOOT.

## Test plan
- Boot:
  - Stimulus: release `Rst_n`, then run 4 cycles with no stall.
  - Response: `PCResult` sequence is 0, 0, 4, 8. `IF_ID_Valid` first goes high after the edge that fetches PC=0, with `IF_ID_PCPlus4`=4.
- Stall:
  - Stimulus: at PC=0x10, hold `Stall`=1 for 3 cycles.
  - Response: `PCNext`=0x10 throughout. IF/ID holds its prior instruction unchanged. Fetch resumes with 0x14.
- Unstalled redirect:
  - Stimulus: at PC=0x20, assert `Redirect` with target 0x100.
  - Response: next `PCResult`=0x100. IF/ID goes valid=0 for one cycle, then holds `IF_ID_PCPlus4`=0x104.
- Deferred redirect:
  - Stimulus: `Stall`=1 with `Redirect` to 0x200, then a second `Redirect` to 0x300 while still stalled, then release the stall.
  - Response: `RedirectPending`=1 during the stall. PC is held. After release, `PCResult`=0x300 and `RedirectPending`=0.
- Flush vs stall and wrap:
  - Stimulus: `Flush`=1 together with `Stall`=1.
  - Response: IF/ID goes valid=0 with instruction 0, and the PC is held.
  - Stimulus: PC=0xFFFF_FFFC, unstalled.
  - Response: `PCNext`=0.
- Mid-run reset:
  - Stimulus: assert `Rst_n`=0 in PEND.
  - Response: `RedirectPending`=0 and IF/ID cleared immediately. `PCNext`=`RESET_PC`.
